// File: rtl/stepdown_gate_seq.sv
// Non-overlap gate sequencer: turns the loop PWM request into high/low-side gate enables with dead time,
// min on/off, max on-time and blanked OCP. Optional diode emulation (DCM) under macro STEPDOWN_ZCD_EN.
module stepdown_gate_seq #(
    parameter int CNT_W    = 8,
    parameter int DEADTIME = 3,
    parameter int MIN_ON   = 4,
    parameter int MIN_OFF  = 2,
    parameter int MAX_ON   = 200,
    parameter int BLANK    = 2
) (
    input  logic       CELCLK,
    input  logic       CELRSTN,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    input  logic       en,
    input  logic       pwm,
    input  logic       ocp,
`ifdef STEPDOWN_ZCD_EN
    input  logic       zcd,
`endif
    output logic       hs_on,
    output logic       ls_on,
    output logic       ocp_evt,
    output logic       maxon_evt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DTH  = 3'd1,
        HS   = 3'd2,
        DTL  = 3'd3,
        LS   = 3'd4,
        DCM  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DT_LAST     = CNT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] MINON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MINOFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] MAXON_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] BLANK_C     = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs_q, ls_q;
    logic             ocp_evt_q, ocp_evt_d;
    logic             maxon_evt_q, maxon_evt_d;

    // Supply/substrate pins exist for netlist connectivity only.
    logic unused_supply;
    assign unused_supply = CELV ^ CELG ^ SUB;

    always_comb begin
        state_d     = state_q;
        ocp_evt_d   = 1'b0;
        maxon_evt_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (pwm) state_d = DTH;
                DTH:  if (cnt_q >= DT_LAST) state_d = HS;
                HS: begin
                    // OCP after blanking wins over both MAX_ON and MIN_ON.
                    if (ocp && (cnt_q >= BLANK_C)) begin
                        state_d   = DTL;
                        ocp_evt_d = 1'b1;
                    end else if (cnt_q == MAXON_LAST) begin
                        state_d     = DTL;
                        maxon_evt_d = 1'b1;
                    end else if (!pwm && (cnt_q >= MINON_LAST)) begin
                        state_d = DTL;
                    end
                end
                DTL:  if (cnt_q >= DT_LAST) state_d = LS;
                LS: begin
                    if (pwm && (cnt_q >= MINOFF_LAST)) begin
                        state_d = DTH;
                    end
`ifdef STEPDOWN_ZCD_EN
                    else if (zcd && (cnt_q >= MINOFF_LAST)) begin
                        state_d = DCM;
                    end
`endif
                end
                DCM:  if (pwm) state_d = DTH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Gate enables are decoded from the next state so they change on the same edge as the state register.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hs_q        <= 1'b0;
            ls_q        <= 1'b0;
            ocp_evt_q   <= 1'b0;
            maxon_evt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hs_q        <= (state_d == HS);
            ls_q        <= (state_d == LS);
            ocp_evt_q   <= ocp_evt_d;
            maxon_evt_q <= maxon_evt_d;
        end
    end

    assign hs_on     = hs_q;
    assign ls_on     = ls_q;
    assign ocp_evt   = ocp_evt_q;
    assign maxon_evt = maxon_evt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_stepdown_gate_seq.sv
// Directed bench for stepdown_gate_seq: each step queues the expected {state, hs, ls, ocp_evt, maxon_evt}
// and pops it after the edge; gate overlap and dead time are checked on every observed cycle.
module tb_stepdown_gate_seq;
  localparam int DEADTIME = 3;

  logic clk = 1'b0;
  logic rst_n, en_r, pwm_r, ocp_r, zcd_r;
  logic hs_on, ls_on, ocp_evt, maxon_evt;
  logic [2:0] state_o;

  logic [6:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int step_no = 0;
  int last_gate = 0;
  int gap = 0;

  always #5 clk = ~clk;

  stepdown_gate_seq dut (
    .CELCLK   (clk),
    .CELRSTN  (rst_n),
    .CELV     (1'b1),
    .CELG     (1'b0),
    .SUB      (1'b0),
    .en       (en_r),
    .pwm      (pwm_r),
    .ocp      (ocp_r),
`ifdef STEPDOWN_ZCD_EN
    .zcd      (zcd_r),
`endif
    .hs_on    (hs_on),
    .ls_on    (ls_on),
    .ocp_evt  (ocp_evt),
    .maxon_evt(maxon_evt),
    .state_o  (state_o)
  );

  task automatic cyc(input logic p, input logic o, input logic [2:0] st,
                     input logic oe = 1'b0, input logic me = 1'b0);
    logic [6:0] exp_v;
    logic [6:0] got_v;
    pwm_r = p;
    ocp_r = o;
    exp_q.push_back({st, (st == 3'd2), (st == 3'd4), oe, me});
    @(posedge clk);
    #1;
    step_no++;
    got_v = {state_o, hs_on, ls_on, ocp_evt, maxon_evt};
    exp_v = exp_q.pop_front();
    total++;
    assert (got_v === exp_v)
      else begin
        bad++;
        $error("FAIL outputs step=%0d got st/hs/ls/oe/me=%b expected=%b", step_no, got_v, exp_v);
      end
    total++;
    assert ((hs_on & ls_on) === 1'b0)
      else begin
        bad++;
        $error("FAIL overlap step=%0d hs=%b ls=%b expected both not high", step_no, hs_on, ls_on);
      end
    if (hs_on === 1'b1) begin
      if (last_gate == 2) begin
        total++;
        assert (gap >= DEADTIME)
          else begin
            bad++;
            $error("FAIL deadtime_ls_hs step=%0d gap=%0d expected>=%0d", step_no, gap, DEADTIME);
          end
      end
      last_gate = 1;
      gap = 0;
    end else if (ls_on === 1'b1) begin
      if (last_gate == 1) begin
        total++;
        assert (gap >= DEADTIME)
          else begin
            bad++;
            $error("FAIL deadtime_hs_ls step=%0d gap=%0d expected>=%0d", step_no, gap, DEADTIME);
          end
      end
      last_gate = 2;
      gap = 0;
    end else begin
      gap++;
    end
  endtask

  task automatic run(input int n, input logic p, input logic o, input logic [2:0] st);
    for (int i = 0; i < n; i++) cyc(p, o, st);
  endtask

  initial begin
    rst_n = 1'b0; en_r = 1'b0; pwm_r = 1'b0; ocp_r = 1'b0; zcd_r = 1'b0;
    run(2, 1'b0, 1'b0, 3'd0);

    // Steady request: DTH 3, HS 200, maxon pulse, DTL 3, LS 2, back to DTH.
    rst_n = 1'b1; en_r = 1'b1;
    run(3, 1'b1, 1'b0, 3'd1);
    run(200, 1'b1, 1'b0, 3'd2);
    cyc(1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
    run(2, 1'b1, 1'b0, 3'd3);
    run(2, 1'b1, 1'b0, 3'd4);
    cyc(1'b1, 1'b0, 3'd1);

    // en drop from DTH, then a one-cycle pwm request still yields MIN_ON.
    en_r = 1'b0;
    cyc(1'b1, 1'b0, 3'd0);
    en_r = 1'b1;
    cyc(1'b1, 1'b0, 3'd1);
    run(2, 1'b0, 1'b0, 3'd1);
    run(4, 1'b0, 1'b0, 3'd2);
    run(3, 1'b0, 1'b0, 3'd3);
    run(5, 1'b0, 1'b0, 3'd4);

    // OCP blanking: ignored at cnt=1, honoured at cnt=2 ahead of MIN_ON.
    cyc(1'b1, 1'b0, 3'd1);
    run(2, 1'b1, 1'b0, 3'd1);
    run(2, 1'b1, 1'b0, 3'd2);
    cyc(1'b1, 1'b1, 3'd2);
    cyc(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0, 3'd3);
    run(3, 1'b0, 1'b0, 3'd4);

    // OCP coinciding with MAX_ON: only ocp_evt pulses.
    cyc(1'b1, 1'b0, 3'd1);
    run(2, 1'b1, 1'b0, 3'd1);
    run(200, 1'b1, 1'b0, 3'd2);
    cyc(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0, 3'd3);
    run(2, 1'b0, 1'b0, 3'd4);

    // en deassert mid-HS at cnt=50, then re-enable through full dead time.
    cyc(1'b1, 1'b0, 3'd1);
    run(2, 1'b1, 1'b0, 3'd1);
    run(51, 1'b1, 1'b0, 3'd2);
    en_r = 1'b0;
    cyc(1'b1, 1'b0, 3'd0);
    en_r = 1'b1;
    run(3, 1'b1, 1'b0, 3'd1);
    cyc(1'b1, 1'b0, 3'd2);
    run(3, 1'b0, 1'b0, 3'd2);
    run(3, 1'b0, 1'b0, 3'd3);
    run(2, 1'b0, 1'b0, 3'd4);

    // Synchronous reset mid-LS.
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    run(3, 1'b1, 1'b0, 3'd1);
    cyc(1'b1, 1'b0, 3'd2);

`ifdef STEPDOWN_ZCD_EN
    // Diode emulation: zcd ignored at LS cnt=0, taken at cnt=1.
    run(3, 1'b0, 1'b0, 3'd2);
    run(3, 1'b0, 1'b0, 3'd3);
    cyc(1'b0, 1'b0, 3'd4);
    zcd_r = 1'b1;
    cyc(1'b0, 1'b0, 3'd4);
    cyc(1'b0, 1'b0, 3'd5);
    zcd_r = 1'b0;
    run(2, 1'b0, 1'b0, 3'd5);
    run(3, 1'b1, 1'b0, 3'd1);
    cyc(1'b1, 1'b0, 3'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish expected<200000ns");
    $fatal(1);
  end
endmodule
